// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and a width helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                bits = i + 32'd1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (slave) and its environment (master).
interface reset_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned NUM_LOCKS   = 2
);
    import reset_seq_pkg::*;

    localparam int unsigned SW = clog2(NUM_DOMAINS + 32'd1);

    logic                   i_button_n;
    logic                   i_soft_reset;
    logic [NUM_LOCKS-1:0]   i_locks;
    logic [NUM_DOMAINS-1:0] o_domain_reset;
    logic                   o_all_released;
    logic                   o_timeout;
    logic [SW-1:0]          o_stage;

    modport master (
        output i_button_n, i_soft_reset, i_locks,
        input  o_domain_reset, o_all_released, o_timeout, o_stage
    );

    modport slave (
        input  i_button_n, i_soft_reset, i_locks,
        output o_domain_reset, o_all_released, o_timeout, o_stage
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // shift the asynchronous level through two stages
    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // synchroniser registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS resets in index order, each gated on its subset of lock inputs,
// with button debounce, per-domain hold time, lock-loss re-sequencing and lock-wait timeout.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned                        NUM_DOMAINS     = 4,
    parameter int unsigned                        NUM_LOCKS       = 2,
    parameter logic [NUM_DOMAINS*NUM_LOCKS-1:0]   LOCK_MASK       = '1,
    parameter int unsigned                        HOLD_CYCLES     = 16,
    parameter int unsigned                        DEBOUNCE_CYCLES = 1024,
    parameter int unsigned                        TIMEOUT_CYCLES  = 1048576
) (
    input  logic             i_clock,
    input  logic             i_reset,
    reset_sequencer_if.slave bus
);
    localparam int unsigned SW      = clog2(NUM_DOMAINS + 32'd1);
    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW      = clog2(CNT_MAX + 32'd1);
    localparam int unsigned WW      = clog2(TIMEOUT_CYCLES + 32'd1);

    localparam logic [CW-1:0] DEBOUNCE_LOAD = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD     = CW'(HOLD_CYCLES - 32'd1);
    localparam logic [WW-1:0] WAIT_MAX      = WW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] LAST_STAGE    = SW'(NUM_DOMAINS - 32'd1);

    logic                   button_sync_s;
    logic [NUM_LOCKS-1:0]   locks_sync_s;
    logic [NUM_DOMAINS-1:0] lost_vec_s;
    logic [SW-1:0]          loss_idx_s;
    logic                   stage_met_s;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [SW-1:0]          stage_q, stage_d;
    logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_d;
    logic                   all_released_q, all_released_d;
    logic                   timeout_q, timeout_d;

    function automatic logic [NUM_LOCKS-1:0] need_of(input logic [SW-1:0] dom);
        logic [NUM_LOCKS-1:0] need;
        need = {NUM_LOCKS{1'b0}};
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            need = (dom == SW'(i)) ? LOCK_MASK[i*NUM_LOCKS +: NUM_LOCKS] : need;
        end
        return need;
    endfunction

    sync_2ff u_button_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (bus.i_button_n),
        .o_q     (button_sync_s)
    );

    for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_lock_sync
        sync_2ff u_lock_sync (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_d     (bus.i_locks[g]),
            .o_q     (locks_sync_s[g])
        );
    end

    // lock status: which released domains lost a lock, the lowest of them, and the current stage's prerequisites
    always_comb begin
        loss_idx_s = {SW{1'b0}};
        for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
            lost_vec_s[d] = ~domain_reset_q[d] &
                            ((locks_sync_s & need_of(SW'(d))) != need_of(SW'(d)));
        end
        for (int d = int'(NUM_DOMAINS) - 1; d >= 0; d--) begin
            loss_idx_s = lost_vec_s[d] ? SW'(d) : loss_idx_s;
        end
        stage_met_s = ((locks_sync_s & need_of(stage_q)) == need_of(stage_q));
    end

    // sequencing FSM; button press and soft reset outrank lock loss, which outranks normal progress
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wait_d         = wait_q;
        stage_d        = stage_q;
        domain_reset_d = domain_reset_q;
        timeout_d      = timeout_q;
        if (!button_sync_s || bus.i_soft_reset) begin
            state_d        = ST_ASSERT;
            cnt_d          = DEBOUNCE_LOAD;
            wait_d         = {WW{1'b0}};
            stage_d        = {SW{1'b0}};
            domain_reset_d = {NUM_DOMAINS{1'b1}};
        end else if ((state_q != ST_ASSERT) && (|lost_vec_s)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = HOLD_LOAD;
            wait_d  = {WW{1'b0}};
            stage_d = loss_idx_s;
            for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
                domain_reset_d[d] = (SW'(d) >= loss_idx_s) ? 1'b1 : domain_reset_q[d];
            end
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    domain_reset_d = {NUM_DOMAINS{1'b1}};
                    stage_d        = {SW{1'b0}};
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (stage_met_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        wait_d    = (wait_q == WAIT_MAX) ? wait_q : wait_q + WW'(1);
                        timeout_d = (wait_q >= WAIT_MAX - WW'(1)) ? 1'b1 : timeout_q;
                    end
                end
                ST_HOLD: begin
                    if (!stage_met_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = HOLD_LOAD;
                        wait_d  = {WW{1'b0}};
                    end else if (cnt_q == {CW{1'b0}}) begin
                        for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
                            domain_reset_d[d] = (SW'(d) == stage_q) ? 1'b0 : domain_reset_q[d];
                        end
                        stage_d = stage_q + SW'(1);
                        wait_d  = {WW{1'b0}};
                        if (stage_q == LAST_STAGE) begin
                            state_d   = ST_RUN;
                            timeout_d = 1'b0;
                        end else begin
                            state_d = ST_WAIT_LOCK;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d        = ST_ASSERT;
                    cnt_d          = DEBOUNCE_LOAD;
                    domain_reset_d = {NUM_DOMAINS{1'b1}};
                end
            endcase
        end
        all_released_d = (state_d == ST_RUN);
    end

    // state and output registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_ASSERT;
            cnt_q          <= DEBOUNCE_LOAD;
            wait_q         <= {WW{1'b0}};
            stage_q        <= {SW{1'b0}};
            domain_reset_q <= {NUM_DOMAINS{1'b1}};
            all_released_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wait_q         <= wait_d;
            stage_q        <= stage_d;
            domain_reset_q <= domain_reset_d;
            all_released_q <= all_released_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.o_domain_reset = domain_reset_q;
    assign bus.o_all_released = all_released_q;
    assign bus.o_timeout      = timeout_q;
    assign bus.o_stage        = stage_q;

endmodule
